obstacle_spawn_scheduler: RTL and testbench

Sits directly downstream of the 10-bit LFSR random source and consumes its `random_out` word. On a random interval measured in frame ticks, it turns random values into spawn requests: an X position limited to the legal screen range, plus an object type. Requests go to the object manager over a valid/ready handshake. The block also counts live objects and stalls spawning while the on-screen limit is reached.

---
 rtl/obstacle_spawn_scheduler.sv | 157 +++++++++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_spawn_scheduler
//
// Purpose:
//   Turns the LFSR random word into obstacle spawn requests. After a random
//   number of video frames it captures an X position, reduced into the legal
//   screen range, and offers it with an object type to the object manager over
//   a valid/ready handshake. It also tracks how many objects are alive and
//   holds off spawning while the on-screen limit is reached.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   en           game running (level)
//   frame_tick   one-cycle pulse per video frame
//   rand_in      10-bit random word, new value every cycle
//   spawn_valid  spawn request pending (registered)
//   spawn_ready  object manager accepts the request
//   spawn_x      spawn X position, 0..X_MAX (registered)
//   spawn_type   object type (registered)
//   obj_done     one-cycle pulse when an object leaves the screen
//   active_cnt   live-object count (registered)
//   full         active_cnt == MAX_ACTIVE (combinational)
// -----------------------------------------------------------------------------
module obstacle_spawn_scheduler #(
  parameter int X_MAX      = 600,
  parameter int GAP_MIN    = 30,
  parameter int GAP_BITS   = 5,
  parameter int MAX_ACTIVE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       frame_tick,
  input  logic [9:0] rand_in,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [9:0] spawn_x,
  output logic [1:0] spawn_type,
  input  logic       obj_done,
  output logic [3:0] active_cnt,
  output logic       full
);

  localparam logic [7:0] GAP_MIN_W = 8'(GAP_MIN);
  localparam logic [9:0] X_MAX_W   = 10'(X_MAX);
  localparam logic [9:0] X_WRAP_W  = 10'(X_MAX + 1);
  localparam logic [3:0] MAX_W     = 4'(MAX_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  state_t     r_state,     w_state_nxt;
  logic [7:0] r_gap_cnt,   w_gap_cnt_nxt;
  logic       r_valid,     w_valid_nxt;
  logic [9:0] r_x,         w_x_nxt;
  logic [1:0] r_type,      w_type_nxt;
  logic [3:0] r_cnt,       w_cnt_nxt;

  logic       w_full;
  logic       w_transfer;
  logic [7:0] w_gap_reload;

  // Because X_MAX >= 511, a 10-bit word is below 2*(X_MAX+1), so a single
  // conditional subtraction always lands in 0..X_MAX.
  function automatic logic [9:0] reduce_x(input logic [9:0] r);
    if (r <= X_MAX_W) begin
      return r;
    end
    return r - X_WRAP_W;
  endfunction

  assign w_full       = (r_cnt == MAX_W);
  assign w_transfer   = r_valid & spawn_ready;
  assign w_gap_reload = GAP_MIN_W + 8'(rand_in[GAP_BITS-1:0]);

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_cnt_nxt = r_gap_cnt;
    w_valid_nxt   = r_valid;
    w_x_nxt       = r_x;
    w_type_nxt    = r_type;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_gap_cnt_nxt = w_gap_reload;
          w_type_nxt    = rand_in[1:0];
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt != 8'd0) begin
          if (frame_tick) begin
            w_gap_cnt_nxt = r_gap_cnt - 8'd1;
          end
        end else if (!w_full) begin
          // Expired gap and room on screen: capture and start offering.
          w_x_nxt     = reduce_x(rand_in);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // The offer is never withdrawn; en only selects where we go after it.
        if (w_transfer) begin
          w_valid_nxt   = 1'b0;
          w_gap_cnt_nxt = w_gap_reload;
          w_type_nxt    = rand_in[1:0];
          w_state_nxt   = en ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    // A transfer and an obj_done in the same cycle cancel out.
    if (w_transfer && !obj_done) begin
      w_cnt_nxt = r_cnt + 4'd1;
    end else if (!w_transfer && obj_done && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 8'd0;
      r_valid   <= 1'b0;
      r_x       <= 10'd0;
      r_type    <= 2'd0;
      r_cnt     <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_x       <= w_x_nxt;
      r_type    <= w_type_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign spawn_valid = r_valid;
  assign spawn_x     = r_x;
  assign spawn_type  = r_type;
  assign active_cnt  = r_cnt;
  assign full        = w_full;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawn_scheduler
//
// Self-checking bench for obstacle_spawn_scheduler. Directed scenarios check
// fixed expectations; a randomized run compares every output against a
// behavioural model of the scheduler kept in this file.
// -----------------------------------------------------------------------------
module tb_obstacle_spawn_scheduler;

  localparam int X_MAX      = 600;
  localparam int GAP_MIN    = 30;
  localparam int GAP_BITS   = 5;
  localparam int MAX_ACTIVE = 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       frame_tick;
  logic [9:0] rand_in;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [1:0] spawn_type;
  logic       obj_done;
  logic [3:0] active_cnt;
  logic       full;

  int errors = 0;
  int checks = 0;

  obstacle_spawn_scheduler #(
    .X_MAX(X_MAX), .GAP_MIN(GAP_MIN), .GAP_BITS(GAP_BITS), .MAX_ACTIVE(MAX_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_tick(frame_tick), .rand_in(rand_in),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_x(spawn_x),
    .spawn_type(spawn_type), .obj_done(obj_done), .active_cnt(active_cnt),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // running: game has an armed countdown; pending: a request is on offer.
  bit m_running;
  bit m_pending;
  int m_frames_left;
  int m_x;
  int m_type;
  int m_live;

  task automatic model_reset();
    m_running = 0; m_pending = 0; m_frames_left = 0;
    m_x = 0; m_type = 0; m_live = 0;
  endtask

  task automatic arm_countdown(input int r);
    m_frames_left = GAP_MIN + (r % (1 << GAP_BITS));
    m_type        = r % 4;
  endtask

  task automatic model_step();
    bit accepted;
    bit at_limit;
    int r;
    r        = int'(rand_in);
    accepted = m_pending && spawn_ready;
    at_limit = (m_live == MAX_ACTIVE);
    if (accepted && !obj_done) m_live = m_live + 1;
    else if (!accepted && obj_done && m_live > 0) m_live = m_live - 1;
    if (m_pending) begin
      if (accepted) begin
        m_pending = 0;
        arm_countdown(r);
        m_running = en;
      end
    end else if (!m_running) begin
      if (en) begin
        arm_countdown(r);
        m_running = 1;
      end
    end else if (!en) begin
      m_running = 0;
    end else if (m_frames_left > 0) begin
      if (frame_tick) m_frames_left = m_frames_left - 1;
    end else if (!at_limit) begin
      m_x       = r % (X_MAX + 1);
      m_pending = 1;
    end
  endtask

  // One clock: model follows the DUT edge; outputs are then sampled 1ns later
  // and rand_in gets a fresh value (callers may override it afterwards).
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
    rand_in = 10'($urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    en = 0; spawn_ready = 0; frame_tick = 0; obj_done = 0;
    rst = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic wait_for_offer(input string name);
    int n;
    n = 0;
    while (!spawn_valid && n < 400) begin
      tick();
      n++;
    end
    if (!spawn_valid) begin
      errors++; checks++;
      $display("FAIL %s: timeout waiting for spawn_valid, got %0b need 1", name, spawn_valid);
    end
  endtask

  task automatic wait_for_count(input int target, input string name);
    int n;
    n = 0;
    while (active_cnt != 4'(target) && n < 2000) begin
      tick();
      n++;
    end
    if (active_cnt != 4'(target)) begin
      errors++; checks++;
      $display("FAIL %s: timeout, active_cnt=%0d need %0d", name, active_cnt, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; en = 0; spawn_ready = 0; frame_tick = 0; obj_done = 0; rand_in = 0;
    model_reset();
    #2;
    checks++;
    if (spawn_valid !== 1'b0 || spawn_x !== 10'd0 || spawn_type !== 2'd0 ||
        active_cnt !== 4'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b x=%0d type=%0d cnt=%0d full=%0b need all 0",
               spawn_valid, spawn_x, spawn_type, active_cnt, full);
    end
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_range();
    int vals[4] = '{600, 601, 700, 1023};
    int exps[4] = '{600, 0, 99, 422};
    do_reset();
    en = 1; frame_tick = 1; spawn_ready = 0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (!(m_running && !m_pending && m_frames_left == 0) && n < 200) begin
        tick();
        n++;
      end
      rand_in = 10'(vals[i]);
      tick();
      checks++;
      if (spawn_valid !== 1'b1 || spawn_x !== 10'(exps[i])) begin
        errors++;
        $display("FAIL range_%0d: valid=%0b x=%0d need valid=1 x=%0d",
                 vals[i], spawn_valid, spawn_x, exps[i]);
      end
      spawn_ready = 1;
      tick();
      spawn_ready = 0;
    end
    frame_tick = 0;
  endtask

  task automatic test_gap_timing();
    int ticks, since;
    bit seen;
    ticks = 0; since = 0; seen = 0;
    do_reset();
    en = 1; spawn_ready = 1;
    rand_in = 10'h0A5;  // low five bits 5 -> 35 frames, type 1
    tick();
    for (int c = 0; c < 200 && !seen; c++) begin
      frame_tick = (c % 3 == 0);
      tick();
      if (frame_tick) begin
        ticks++;
        since = 0;
      end else begin
        since++;
      end
      if (spawn_valid) begin
        seen = 1;
        checks++;
        if (ticks !== 35 || since !== 1) begin
          errors++;
          $display("FAIL gap_timing: valid after %0d ticks (+%0d cycles) need 35 (+1)", ticks, since);
        end
        checks++;
        if (spawn_type !== 2'd1) begin
          errors++;
          $display("FAIL gap_type: spawn_type=%0d need 1", spawn_type);
        end
      end
    end
    frame_tick = 0;
    if (!seen) begin
      errors++; checks++;
      $display("FAIL gap_timing: spawn_valid never asserted after %0d ticks", ticks);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [9:0] x0;
    logic [1:0] t0;
    logic [3:0] c0;
    bit bad;
    do_reset();
    en = 1; frame_tick = 1; spawn_ready = 0;
    wait_for_offer("backpressure");
    x0 = spawn_x; t0 = spawn_type; c0 = active_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spawn_valid !== 1'b1 || spawn_x !== x0 || spawn_type !== t0 || active_cnt !== c0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold: valid=%0b x=%0d type=%0d cnt=%0d need 1 %0d %0d %0d",
               spawn_valid, spawn_x, spawn_type, active_cnt, x0, t0, c0);
    end
    spawn_ready = 1;
    tick();
    spawn_ready = 0;
    checks++;
    if (spawn_valid !== 1'b0 || active_cnt !== c0 + 4'd1) begin
      errors++;
      $display("FAIL backpressure_xfer: valid=%0b cnt=%0d need 0 %0d", spawn_valid, active_cnt, c0 + 4'd1);
    end
    frame_tick = 0;
  endtask

  task automatic test_full_stall();
    bit bad;
    do_reset();
    en = 1; frame_tick = 1; spawn_ready = 1;
    wait_for_count(8, "full_fill");
    spawn_ready = 0;
    checks++;
    if (full !== 1'b1 || active_cnt !== 4'd8) begin
      errors++;
      $display("FAIL full_flag: full=%0b cnt=%0d need 1 8", full, active_cnt);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (spawn_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_stall: spawn_valid=1 while full, need 0");
    end
    obj_done = 1;
    tick();
    obj_done = 0;
    checks++;
    if (active_cnt !== 4'd7 || full !== 1'b0 || spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_release: cnt=%0d full=%0b valid=%0b need 7 0 0", active_cnt, full, spawn_valid);
    end
    tick();
    checks++;
    if (spawn_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_capture: valid=%0b need 1", spawn_valid);
    end
    frame_tick = 0;
  endtask

  task automatic test_simultaneous();
    bit bad;
    do_reset();
    en = 1; frame_tick = 1; spawn_ready = 1;
    wait_for_count(3, "simul_fill");
    spawn_ready = 0;
    wait_for_offer("simul_offer");
    spawn_ready = 1; obj_done = 1;
    tick();
    spawn_ready = 0; obj_done = 0;
    checks++;
    if (active_cnt !== 4'd3 || spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL xfer_and_done: cnt=%0d valid=%0b need 3 0", active_cnt, spawn_valid);
    end
    do_reset();
    obj_done = 1;
    tick();
    obj_done = 0;
    checks++;
    if (active_cnt !== 4'd0) begin
      errors++;
      $display("FAIL done_at_zero: cnt=%0d need 0", active_cnt);
    end
    en = 1; frame_tick = 1; spawn_ready = 0;
    wait_for_offer("en_low_offer");
    en = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (spawn_valid !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_low_hold: spawn_valid dropped while en=0, need 1");
    end
    spawn_ready = 1;
    tick();
    checks++;
    if (spawn_valid !== 1'b0 || active_cnt !== 4'd1) begin
      errors++;
      $display("FAIL en_low_xfer: valid=%0b cnt=%0d need 0 1", spawn_valid, active_cnt);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (spawn_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_low_idle: spawn_valid=1 with en=0, need 0");
    end
    spawn_ready = 0; frame_tick = 0;
  endtask

  task automatic test_reset_mid_offer();
    bit bad;
    do_reset();
    en = 1; frame_tick = 1; spawn_ready = 1;
    wait_for_count(2, "rmo_fill");
    spawn_ready = 0;
    wait_for_offer("rmo_offer");
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (spawn_valid !== 1'b0 || spawn_x !== 10'd0 || active_cnt !== 4'd0 || spawn_type !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_offer: valid=%0b x=%0d cnt=%0d type=%0d need all 0",
               spawn_valid, spawn_x, active_cnt, spawn_type);
    end
    spawn_ready = 1;
    tick();
    tick();
    rst = 1; spawn_ready = 0;
    rand_in = 10'h0A5;
    tick();  // reload to 35 frames
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (spawn_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_reset_early: spawn_valid before 35 frames, need 0");
    end
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_type !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_reload: valid=%0b type=%0d need 1 1", spawn_valid, spawn_type);
    end
    frame_tick = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      en          = ($urandom_range(0, 99) < 95);
      frame_tick  = ($urandom_range(0, 3) != 0);
      spawn_ready = ($urandom_range(0, 1) == 1);
      obj_done    = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (spawn_valid !== 1'(m_pending) || spawn_x !== 10'(m_x) || spawn_type !== 2'(m_type) ||
          active_cnt !== 4'(m_live) || full !== 1'(m_live == MAX_ACTIVE)) begin
        errors++;
        $display("FAIL random_cycle_%0d: got v=%0b x=%0d t=%0d c=%0d f=%0b need v=%0b x=%0d t=%0d c=%0d",
                 i, spawn_valid, spawn_x, spawn_type, active_cnt, full,
                 m_pending, m_x, m_type, m_live);
      end
    end
    en = 0; frame_tick = 0; spawn_ready = 0; obj_done = 0;
  endtask

  initial begin
    test_reset();
    test_range();
    test_gap_timing();
    test_backpressure();
    test_full_stall();
    test_simultaneous();
    test_reset_mid_offer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
